seven_seg_capture: RTL and testbench

- Reverse of the hex-to-segment decoders: samples a multiplexed, active-high 7-segment display bus (segment lines plus one-hot digit select) and recovers the hex digit shown on each position.
- Debounces each strobe and decodes the segment pattern back to a nibble.
- Assembles a NUM_DIGITS-wide frame and hands it downstream over a valid/ready handshake.
- Used by display self-check logic and by the board-level test harness.

---
 rtl/seven_seg_capture_pkg.sv | 16 +
 rtl/seven_seg_capture_pattern_decode.sv | 22 ++
 rtl/seven_seg_capture.sv | 111 +++++++++++
 tb/tb_seven_seg_capture.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_capture_pkg.sv
// Shared constants for the seven-segment capture path: the segment decode
// table (active-high {g,f,e,d,c,b,a}) and the capture FSM state encoding.
package seven_seg_capture_pkg;

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_HELD = 1'b1
  } cap_state_t;

  // Entry n is the segment pattern that displays hex digit n.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

endpackage

// File: rtl/seven_seg_capture_pattern_decode.sv
// Combinational segment-pattern to nibble decoder; unknown patterns give
// nibble 0 with err set.
module seven_seg_pattern_decode
  import seven_seg_capture_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       err
);

  always_comb begin
    nibble = 4'h0;
    err    = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TABLE[i]) begin
        nibble = 4'(i);
        err    = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seven_seg_capture.sv
// Samples a multiplexed seven-segment bus, debounces each digit strobe and
// assembles the decoded digits into frames for a downstream consumer.
module seven_seg_capture
  import seven_seg_capture_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   dig_sel,
  input  logic                    out_ready,
  output logic                    out_valid,
  output logic [4*NUM_DIGITS-1:0] out_digits,
  output logic [NUM_DIGITS-1:0]   out_err,
  output logic                    busy
);

  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [6:0]              seg_s1, seg_s2, seg_prev;
  logic [NUM_DIGITS-1:0]   sel_s1, sel_s2, sel_prev;
  logic [CW-1:0]           cnt;
  cap_state_t              state;
  logic [4*NUM_DIGITS-1:0] slot_digit;
  logic [NUM_DIGITS-1:0]   slot_err;
  logic [NUM_DIGITS-1:0]   seen;

  logic [3:0]    dec_nibble;
  logic          dec_err;
  logic          same;
  logic          sel_onehot;
  logic [CW-1:0] cnt_next;
  logic          capture;
  logic          load;

  seven_seg_pattern_decode u_decode (
    .seg    (seg_s2),
    .nibble (dec_nibble),
    .err    (dec_err)
  );

  always_comb begin
    same       = (seg_s2 == seg_prev) && (sel_s2 == sel_prev);
    sel_onehot = (sel_s2 != '0) && ((sel_s2 & (sel_s2 - 1'b1)) == '0);
    cnt_next   = (cnt == CW'(STABLE_CYCLES)) ? cnt : CW'(cnt + 1'b1);
    // Capture fires once, on the sample that completes the stable run.
    capture    = same && (state == ST_WAIT) && (cnt_next == CW'(STABLE_CYCLES))
                 && sel_onehot;
    // Handshake: a frame transfers on any cycle with out_valid & out_ready;
    // the output register may reload in that same cycle.
    load       = (&seen) && (!out_valid || out_ready);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      seg_s1     <= '0;
      seg_s2     <= '0;
      seg_prev   <= '0;
      sel_s1     <= '0;
      sel_s2     <= '0;
      sel_prev   <= '0;
      cnt        <= '0;
      state      <= ST_WAIT;
      slot_digit <= '0;
      slot_err   <= '0;
      seen       <= '0;
      out_valid  <= 1'b0;
      out_digits <= '0;
      out_err    <= '0;
    end else begin
      seg_s1   <= seg;
      seg_s2   <= seg_s1;
      seg_prev <= seg_s2;
      sel_s1   <= dig_sel;
      sel_s2   <= sel_s1;
      sel_prev <= sel_s2;

      if (!same) begin
        cnt   <= CW'(1);
        state <= ST_WAIT;
      end else begin
        cnt <= cnt_next;
        if (capture) state <= ST_HELD;
      end

      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (capture && sel_s2[i]) begin
          slot_digit[4*i +: 4] <= dec_nibble;
          slot_err[i]          <= dec_err;
        end
      end

      // A capture landing on the load cycle starts the next frame.
      if (load) seen <= capture ? sel_s2 : '0;
      else if (capture) seen <= seen | sel_s2;

      if (load) begin
        out_digits <= slot_digit;
        out_err    <= slot_err;
        out_valid  <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  assign busy = (seen != '0);

endmodule

// File: tb/tb_seven_seg_capture.sv
// Bench for seven_seg_capture: directed scenarios plus randomized display
// episodes scored against an episode-level model of the capture rules.
module tb_seven_seg_capture;

  localparam int N  = 4;
  localparam int ST = 8;
  localparam int W  = 5 * N;

  logic           clk = 1'b0;
  logic           reset;
  logic [6:0]     seg;
  logic [N-1:0]   dig_sel;
  logic           out_ready;
  logic           out_valid;
  logic [4*N-1:0] out_digits;
  logic [N-1:0]   out_err;
  logic           busy;

  seven_seg_capture #(.NUM_DIGITS(N), .STABLE_CYCLES(ST)) dut (
    .clk        (clk),
    .reset      (reset),
    .seg        (seg),
    .dig_sel    (dig_sel),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_digits (out_digits),
    .out_err    (out_err),
    .busy       (busy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int valid_cycles = 0;
  logic rand_ready = 1'b0;
  int   low_run = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, expv);
  endtask

  // reference model: what the display shows, one episode at a time
  logic [6:0]   seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [3:0]   m_digit [N];
  logic [N-1:0] m_err;
  logic [N-1:0] m_seen;
  logic [W-1:0] exp_q [$];

  task automatic model_capture(input logic [N-1:0] sel, input logic [6:0] s);
    int idx = 0;
    logic [3:0] nib = 4'h0;
    logic e = 1'b1;
    logic [W-1:0] frame;
    for (int i = 0; i < 16; i++)
      if (seg_tab[i] == s) begin nib = 4'(i); e = 1'b0; end
    for (int i = 0; i < N; i++) if (sel[i]) idx = i;
    m_digit[idx] = nib;
    m_err[idx]   = e;
    m_seen[idx]  = 1'b1;
    if (m_seen == {N{1'b1}}) begin
      for (int i = 0; i < N; i++) frame[4*i +: 4] = m_digit[i];
      frame[W-1:4*N] = m_err;
      exp_q.push_back(frame);
      m_seen = '0;
    end
  endtask

  // driver: hold one (dig_sel, seg) value for a number of clock edges
  task automatic episode(input logic [N-1:0] sel, input logic [6:0] s, input int cycles);
    dig_sel = sel;
    seg     = s;
    if ($countones(sel) == 1 && cycles >= ST) model_capture(sel, s);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    #1;
    if (rand_ready) begin
      out_ready = (low_run >= 3) ? 1'b1 : 1'($urandom_range(0, 1));
      low_run   = out_ready ? 0 : low_run + 1;
    end
  end

  // scoreboard: every transfer must match the oldest expected frame
  always @(negedge clk) begin
    logic [W-1:0] expv;
    if (out_valid) valid_cycles++;
    if (!reset && out_valid && out_ready) begin
      if (exp_q.size() == 0) check("frame_expected", 32'(exp_q.size()), 32'd1);
      else begin
        expv = exp_q.pop_front();
        check("frame_digits", 32'(out_digits), 32'(expv[4*N-1:0]));
        check("frame_err", 32'(out_err), 32'(expv[W-1:4*N]));
      end
    end
  end

  initial begin
    logic [N-1:0] rsel;
    logic [6:0]   rseg;
    int           rlen;
    m_err = '0;
    m_seen = '0;
    for (int i = 0; i < N; i++) m_digit[i] = 4'h0;
    reset = 1'b1; out_ready = 1'b0; seg = '0; dig_sel = '0;

    // reset with the bus toggling
    repeat (3) begin
      @(posedge clk); #1;
      seg = 7'($urandom); dig_sel = N'($urandom);
    end
    @(negedge clk);
    check("reset_valid", 32'(out_valid), 32'd0);
    check("reset_digits", 32'(out_digits), 32'd0);
    check("reset_err", 32'(out_err), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    seg = '0; dig_sel = '0;
    @(posedge clk); #1;
    reset = 1'b0; out_ready = 1'b1;

    // normal frame
    valid_cycles = 0;
    episode(4'b0001, 7'h3F, 20);
    episode(4'b0010, 7'h06, 20);
    episode(4'b0100, 7'h5B, 20);
    episode(4'b1000, 7'h4F, 20);
    episode(4'b0000, 7'h00, 5);
    @(negedge clk);
    check("normal_valid_pulses", 32'(valid_cycles), 32'd1);
    check("normal_digits", 32'(out_digits), 32'h3210);
    @(posedge clk); #1;

    // glitch and multi-hot rejection
    episode(4'b0001, 7'h3F, 20);
    episode(4'b0010, 7'h66, 5);
    episode(4'b0010, 7'h7D, 20);
    @(negedge clk);
    check("glitch_busy_before", 32'(busy), 32'(m_seen != '0));
    @(posedge clk); #1;
    episode(4'b0011, 7'h7D, 30);
    @(negedge clk);
    check("multihot_busy_after", 32'(busy), 32'(m_seen != '0));
    @(posedge clk); #1;
    episode(4'b0100, 7'h5B, 20);
    episode(4'b1000, 7'h4F, 20);
    episode(4'b0000, 7'h00, 5);
    @(negedge clk);
    check("glitch_frame", 32'(out_digits), 32'h3260);
    @(posedge clk); #1;

    // invalid pattern on digit 2
    episode(4'b0001, 7'h3F, 20);
    episode(4'b0010, 7'h3F, 20);
    episode(4'b0100, 7'h00, 20);
    episode(4'b1000, 7'h3F, 20);
    episode(4'b0000, 7'h00, 5);
    @(negedge clk);
    check("invalid_err", 32'(out_err), 32'h4);
    check("invalid_digits", 32'(out_digits), 32'h0);
    @(posedge clk); #1;

    // backpressure: frame A held while frame B completes behind it
    out_ready = 1'b0;
    episode(4'b0001, 7'h3F, 20);
    episode(4'b0010, 7'h06, 20);
    episode(4'b0100, 7'h5B, 20);
    episode(4'b1000, 7'h4F, 20);
    episode(4'b0000, 7'h00, 5);
    @(negedge clk);
    check("bp_a_valid", 32'(out_valid), 32'd1);
    check("bp_a_digits", 32'(out_digits), 32'h3210);
    @(posedge clk); #1;
    episode(4'b0001, 7'h71, 20);
    episode(4'b0010, 7'h79, 20);
    episode(4'b0100, 7'h5E, 20);
    episode(4'b1000, 7'h39, 20);
    episode(4'b0000, 7'h00, 5);
    @(negedge clk);
    check("bp_hold_digits", 32'(out_digits), 32'h3210);
    check("bp_hold_valid", 32'(out_valid), 32'd1);
    check("bp_full_busy", 32'(busy), 32'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check("bp_b_valid", 32'(out_valid), 32'd1);
    check("bp_b_digits", 32'(out_digits), 32'hCDEF);
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // reset mid-frame
    episode(4'b0001, 7'h3F, 20);
    episode(4'b0010, 7'h06, 20);
    episode(4'b0000, 7'h00, 3);
    reset = 1'b1;
    m_seen = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    valid_cycles = 0;
    episode(4'b0001, 7'h7F, 20);
    episode(4'b0010, 7'h6F, 20);
    episode(4'b0100, 7'h77, 20);
    episode(4'b1000, 7'h7C, 20);
    episode(4'b0000, 7'h00, 5);
    @(negedge clk);
    check("midreset_frames", 32'(valid_cycles), 32'd1);
    check("midreset_digits", 32'(out_digits), 32'hBA98);
    @(posedge clk); #1;

    // randomized episodes with bounded random backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 80; k++) begin
      do begin
        case ($urandom_range(0, 9))
          0:       rsel = '0;
          1:       rsel = N'($urandom) | N'(3);
          default: rsel = N'(1) << $urandom_range(0, N - 1);
        endcase
        rseg = ($urandom_range(0, 7) == 0) ? 7'($urandom) : seg_tab[$urandom_range(0, 15)];
      end while (rsel == dig_sel && rseg == seg);
      rlen = ($urandom_range(0, 3) == 0) ? $urandom_range(1, ST - 3)
                                          : $urandom_range(ST + 3, ST + 12);
      episode(rsel, rseg, rlen);
    end
    if (dig_sel == '0 && seg == '0) episode(4'b0000, 7'h01, 40);
    else episode(4'b0000, 7'h00, 40);
    rand_ready = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    check("final_busy", 32'(busy), 32'(m_seen != '0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
